control_multiciclo: RTL

//  Multicycle control FSM for the RV32I subset core (add, sub, addi, lw, sw).

---
 rtl/ctrl_pkg.sv | 50 +++++
 rtl/decodificador_instr.sv | 37 +++
 rtl/control_multiciclo.sv | 118 +++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, instruction classes,
// RV32I opcode/funct fields and operand-B select codes.
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } estado_t;

   typedef enum logic [2:0] {
      CL_R_ADD  = 3'd0,
      CL_R_SUB  = 3'd1,
      CL_ADDI   = 3'd2,
      CL_LW     = 3'd3,
      CL_SW     = 3'd4,
      CL_ILEGAL = 3'd5
   } clase_t;

   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_W   = 3'b010;

   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;

   localparam logic [1:0] SEL_REG   = 2'b00;
   localparam logic [1:0] SEL_IMM_I = 2'b01;
   localparam logic [1:0] SEL_IMM_S = 2'b10;
   localparam logic [1:0] SEL_NONE  = 2'b11;

   function automatic logic [1:0] senal_de_clase(input clase_t c);
      logic [1:0] s;
      case (c)
         CL_R_ADD, CL_R_SUB: s = SEL_REG;
         CL_ADDI, CL_LW:     s = SEL_IMM_I;
         CL_SW:              s = SEL_IMM_S;
         default:            s = SEL_NONE;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/decodificador_instr.sv
// Combinational classifier: maps an RV32I word onto the supported instruction
// classes; anything outside add/sub/addi/lw/sw is reported as CL_ILEGAL.
module decodificador_instr
   import ctrl_pkg::*;
(
   input  logic [31:0] i_instr,
   output clase_t      o_clase
);

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;
   logic       w_unused;

   assign w_opcode = i_instr[6:0];
   assign w_funct3 = i_instr[14:12];
   assign w_funct7 = i_instr[31:25];
   // Register and immediate fields play no part in classification.
   assign w_unused = ^{i_instr[24:15], i_instr[11:7]};

   always_comb begin
      o_clase = CL_ILEGAL;
      if (w_opcode == OPC_R && w_funct3 == F3_ADD) begin
         if (w_funct7 == F7_ADD)
            o_clase = CL_R_ADD;
         else if (w_funct7 == F7_SUB)
            o_clase = CL_R_SUB;
      end else if (w_opcode == OPC_IMM && w_funct3 == F3_ADD) begin
         o_clase = CL_ADDI;
      end else if (w_opcode == OPC_LOAD && w_funct3 == F3_W) begin
         o_clase = CL_LW;
      end else if (w_opcode == OPC_STORE && w_funct3 == F3_W) begin
         o_clase = CL_SW;
      end
   end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle control FSM for the add/sub/addi/lw/sw RV32I core.
// Define CTRL_ILLEGAL_TRAP_EN to park in TRAP on illegal instructions (adds illegal_instr).
module control_multiciclo
   import ctrl_pkg::*;
#(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 32
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      Instruccion,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_sel,
   output logic             ir_we,
   output logic             pc_we,
   output logic             reg_we,
   output logic             wb_sel,
   output logic             alu_op,
   output logic [1:0]       Senal,
   output logic             mem_timeout,
   output logic             retirada,
   output logic [CNT_W-1:0] n_retiradas,
`ifdef CTRL_ILLEGAL_TRAP_EN
   output logic             illegal_instr,
`endif
   output logic [2:0]       estado
);

   localparam logic [7:0] ESPERA_ULT = 8'(WAIT_MAX - 1);

   estado_t          r_estado;
   clase_t           r_clase;
   logic [7:0]       r_espera;
   logic             r_hueco;
   logic [CNT_W-1:0] r_cuenta;

   clase_t w_clase;
   logic   w_fase_mem;
   logic   w_mem_req;
   logic   w_listo;
   logic   w_timeout;
   logic   w_retira;

   decodificador_instr u_deco (
      .i_instr (Instruccion),
      .o_clase (w_clase)
   );

   // r_hueco masks the request for one cycle: after a timeout and after reset release.
   assign w_fase_mem = (r_estado == ST_FETCH) || (r_estado == ST_MEM);
   assign w_mem_req  = w_fase_mem && !r_hueco;
   assign w_listo    = w_mem_req && mem_ready;
   assign w_timeout  = w_mem_req && !mem_ready && (r_espera == ESPERA_ULT);
   assign w_retira   = (r_estado == ST_WB) ||
                       ((r_estado == ST_MEM) && (r_clase == CL_SW) && w_listo);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_estado <= ST_FETCH;
         r_clase  <= CL_ILEGAL;
         r_espera <= '0;
         r_hueco  <= 1'b1;
         r_cuenta <= '0;
      end else begin
         r_hueco <= w_timeout;
         if (w_listo || w_timeout)
            r_espera <= '0;
         else if (w_mem_req)
            r_espera <= r_espera + 8'd1;
         if (w_retira)
            r_cuenta <= r_cuenta + CNT_W'(1);

         case (r_estado)
            ST_FETCH: if (w_listo) r_estado <= ST_DECODE;
            ST_DECODE: begin
               r_clase <= w_clase;
               if (w_clase == CL_ILEGAL)
`ifdef CTRL_ILLEGAL_TRAP_EN
                  r_estado <= ST_TRAP;
`else
                  r_estado <= ST_FETCH;
`endif
               else
                  r_estado <= ST_EXEC;
            end
            ST_EXEC:
               r_estado <= (r_clase == CL_LW || r_clase == CL_SW) ? ST_MEM : ST_WB;
            ST_MEM:
               if (w_listo) r_estado <= (r_clase == CL_LW) ? ST_WB : ST_FETCH;
            ST_WB:   r_estado <= ST_FETCH;
            ST_TRAP: r_estado <= ST_TRAP;
            default: r_estado <= ST_FETCH;
         endcase
      end
   end

   assign mem_req     = w_mem_req;
   assign mem_sel     = (r_estado == ST_MEM);
   assign mem_we      = w_mem_req && (r_estado == ST_MEM) && (r_clase == CL_SW);
   assign ir_we       = (r_estado == ST_FETCH) && w_listo;
   assign pc_we       = (r_estado == ST_FETCH) && w_listo;
   assign reg_we      = (r_estado == ST_WB);
   assign wb_sel      = (r_estado == ST_WB) && (r_clase == CL_LW);
   assign alu_op      = (r_estado == ST_EXEC) && (r_clase == CL_R_SUB);
   assign Senal       = (r_estado == ST_EXEC || r_estado == ST_MEM || r_estado == ST_WB) ?
                        senal_de_clase(r_clase) : SEL_NONE;
   assign mem_timeout = w_timeout;
   assign retirada    = w_retira;
   assign n_retiradas = r_cuenta;
   assign estado      = r_estado;
`ifdef CTRL_ILLEGAL_TRAP_EN
   assign illegal_instr = (r_estado == ST_TRAP);
`endif

endmodule
